// File: rtl/serial_bulk_loader_if.sv
// Synchronous memory bus between a bulk client (master) and a single-port memory (slave).
// The client drives clk/addr/w_data/we; the memory returns r_data one cycle after addr.
interface memory_bus #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  clk;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  we;
    logic [DATA_WIDTH-1:0] r_data;

    modport client (output clk, output addr, output w_data, output we, input r_data);
    modport master (output clk, output addr, output w_data, output we, input r_data);
    modport memory (input clk, input addr, input w_data, input we, output r_data);
    modport slave  (input clk, input addr, input w_data, input we, output r_data);
endinterface

// File: rtl/serial_bulk_loader.sv
// Assembles an 8-bit byte stream little-endian into words and bulk-writes them to memory_bus.
// Optional readback check of every written word is enabled by defining LOADER_VERIFY_EN.
module serial_bulk_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    memory_bus.client             mem
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CMP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  word_exit;

    // State and datapath registers; reset also clears the bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            w_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            w_data_q    <= w_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        word_exit   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = word_count;
                    byte_cnt_d  = '0;
                    state_d     = (word_count == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (byte_cnt_q == CNT_W'(b)) begin
                            word_d[b*8 +: 8] = in_data;
                        end
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            S_WRITE:      state_d = S_VERIFY_RD;
            S_VERIFY_RD:  state_d = S_VERIFY_CMP;
            S_VERIFY_CMP: word_exit = 1'b1;
`else
            S_WRITE:      word_exit = 1'b1;
`endif
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        // Address wraps silently at the top of the address space.
        if (word_exit) begin
            cur_addr_d  = cur_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = (remaining_q == ONE_WORD) ? S_DONE : S_COLLECT;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        in_ready_d = (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        we_d       = (state_d == S_WRITE);
        addr_d     = addr_q;
        w_data_d   = w_data_q;
        if (state_d == S_WRITE) begin
            addr_d   = cur_addr_q;
            w_data_d = word_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    logic error_q, error_d;

    // Sticky until the next accepted start; r_data is valid in VERIFY_CMP.
    always_comb begin
        error_d = error_q;
        if (state_q == S_IDLE && start) begin
            error_d = 1'b0;
        end else if (state_q == S_VERIFY_CMP && mem.r_data != w_data_q) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mem.clk    = clk;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.w_data = w_data_q;

endmodule
